// File: rtl/mix_sequence_ctrl_if.sv
// Host-side bundle for the mixing-chain sequencer: run control, programmed
// durations in, valve/mixer drives and status out.
interface mix_sequence_ctrl_if #(
  parameter int unsigned NUM_SOLN = 3,
  parameter int unsigned CNT_W    = 16
);
  logic                      start;
  logic                      abort;
  logic [NUM_SOLN-1:0]       chan_mask;
  logic [NUM_SOLN*CNT_W-1:0] dwell;
  logic [CNT_W-1:0]          mix_cyc;
  logic [CNT_W-1:0]          flush_cyc;
  logic [NUM_SOLN-1:0]       valve_open;
  logic                      mix_en;
  logic                      out_valve;
  logic                      busy;
  logic [3:0]                cur_chan;
  logic                      done;
  logic                      err;

  modport master (
    output start, abort, chan_mask, dwell, mix_cyc, flush_cyc,
    input  valve_open, mix_en, out_valve, busy, cur_chan, done, err
  );

  modport slave (
    input  start, abort, chan_mask, dwell, mix_cyc, flush_cyc,
    output valve_open, mix_en, out_valve, busy, cur_chan, done, err
  );
endinterface

// File: rtl/mix_sequence_ctrl.sv
// Microfluidic mixing-chain sequencer: dispenses enabled inlet channels one at
// a time in ascending order (each followed by a settle gap), then runs one mix
// phase and one flush phase. All outputs are registered alongside the state.
// SETTLE_CYC must be at least 1.
module mix_sequence_ctrl #(
  parameter int unsigned NUM_SOLN   = 3,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input logic                clk,
  input logic                rst_n,
  mix_sequence_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_SOLN > 1) ? $clog2(NUM_SOLN) : 1;
  localparam logic [NUM_SOLN-1:0] ONE_HOT0  = NUM_SOLN'(1);
  localparam logic [CNT_W-1:0]    SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    DISPENSE,
    SETTLE,
    MIX,
    FLUSH,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_SOLN-1:0] rem;
  logic [CNT_W-1:0]    sh_dwell [NUM_SOLN];
  logic [CNT_W-1:0]    sh_mix;
  logic [CNT_W-1:0]    sh_flush;

  logic [CNT_W-1:0]    dw_in [NUM_SOLN];
  logic [NUM_SOLN-1:0] eff_mask;
  logic [IDX_W-1:0]    first_idx;
  logic                first_any;
  logic [IDX_W-1:0]    next_idx;
  logic                next_any;
  state_t              tail_a;
  logic [CNT_W-1:0]    tail_a_cnt;
  state_t              tail_b;
  logic [CNT_W-1:0]    tail_b_cnt;

  // Unpack per-channel dwell and drop channels whose dwell is zero
  always_comb begin
    for (int unsigned i = 0; i < NUM_SOLN; i++) begin
      dw_in[i]    = bus.dwell[i*CNT_W +: CNT_W];
      eff_mask[i] = bus.chan_mask[i] & (dw_in[i] != '0);
    end
  end

  // Lowest enabled channel at start, and lowest channel still pending mid-run
  always_comb begin
    first_any = |eff_mask;
    first_idx = '0;
    for (int unsigned i = NUM_SOLN; i > 0; i--) begin
      if (eff_mask[i-1]) first_idx = IDX_W'(i - 1);
    end
    next_any = |rem;
    next_idx = '0;
    for (int unsigned i = NUM_SOLN; i > 0; i--) begin
      if (rem[i-1]) next_idx = IDX_W'(i - 1);
    end
  end

  // Resolve zero-length mix/flush phases into the first phase that actually runs
  always_comb begin
    if (sh_mix != '0) begin
      tail_a     = MIX;
      tail_a_cnt = sh_mix - CNT_ONE;
    end else if (sh_flush != '0) begin
      tail_a     = FLUSH;
      tail_a_cnt = sh_flush - CNT_ONE;
    end else begin
      tail_a     = DONE;
      tail_a_cnt = '0;
    end
    if (sh_flush != '0) begin
      tail_b     = FLUSH;
      tail_b_cnt = sh_flush - CNT_ONE;
    end else begin
      tail_b     = DONE;
      tail_b_cnt = '0;
    end
  end

  // Sequencer state, duration counter, shadow config and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      sh_dwell       <= '{default: '0};
      sh_mix         <= '0;
      sh_flush       <= '0;
      bus.valve_open <= '0;
      bus.mix_en     <= 1'b0;
      bus.out_valve  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.cur_chan   <= '0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state          <= IDLE;
        cnt            <= '0;
        rem            <= '0;
        bus.valve_open <= '0;
        bus.mix_en     <= 1'b0;
        bus.out_valve  <= 1'b0;
        bus.busy       <= 1'b0;
        bus.cur_chan   <= '0;
        bus.err        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (!first_any) begin
                bus.err <= 1'b1;
              end else begin
                sh_dwell       <= dw_in;
                sh_mix         <= bus.mix_cyc;
                sh_flush       <= bus.flush_cyc;
                rem            <= eff_mask & ~(ONE_HOT0 << first_idx);
                state          <= DISPENSE;
                cnt            <= dw_in[first_idx] - CNT_ONE;
                bus.valve_open <= ONE_HOT0 << first_idx;
                bus.cur_chan   <= 4'(first_idx);
                bus.busy       <= 1'b1;
              end
            end
          end
          DISPENSE: begin
            if (cnt == '0) begin
              state          <= SETTLE;
              cnt            <= SETTLE_LD;
              bus.valve_open <= '0;
              bus.cur_chan   <= '0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              if (next_any) begin
                state          <= DISPENSE;
                cnt            <= sh_dwell[next_idx] - CNT_ONE;
                rem            <= rem & ~(ONE_HOT0 << next_idx);
                bus.valve_open <= ONE_HOT0 << next_idx;
                bus.cur_chan   <= 4'(next_idx);
              end else begin
                state         <= tail_a;
                cnt           <= tail_a_cnt;
                bus.mix_en    <= (tail_a == MIX);
                bus.out_valve <= (tail_a == FLUSH);
                bus.done      <= (tail_a == DONE);
                bus.busy      <= (tail_a != DONE);
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          MIX: begin
            if (cnt == '0) begin
              state         <= tail_b;
              cnt           <= tail_b_cnt;
              bus.mix_en    <= 1'b0;
              bus.out_valve <= (tail_b == FLUSH);
              bus.done      <= (tail_b == DONE);
              bus.busy      <= (tail_b != DONE);
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          FLUSH: begin
            if (cnt == '0) begin
              state         <= DONE;
              bus.out_valve <= 1'b0;
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mix_sequence_ctrl.sv
// Directed bench for mix_sequence_ctrl. Each cycle the packed output word
// {valve_open, mix_en, out_valve, busy, cur_chan, done, err} is compared
// against a hand-built per-cycle expectation queue.
module tb_mix_sequence_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_sequence_ctrl_if #(.NUM_SOLN(3), .CNT_W(16)) b ();
  mix_sequence_ctrl_if #(.NUM_SOLN(3), .CNT_W(4))  b4 ();

  mix_sequence_ctrl #(.NUM_SOLN(3), .CNT_W(16), .SETTLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );
  mix_sequence_ctrl #(.NUM_SOLN(3), .CNT_W(4), .SETTLE_CYC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  logic [11:0] obs, obs4;
  assign obs  = {b.valve_open, b.mix_en, b.out_valve, b.busy, b.cur_chan, b.done, b.err};
  assign obs4 = {b4.valve_open, b4.mix_en, b4.out_valve, b4.busy, b4.cur_chan, b4.done, b4.err};

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] exp_q[$];

  task automatic add_seg(input logic [2:0] v, input logic m, input logic o, input logic bz,
                         input logic [3:0] ch, input logic d, input logic e, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({v, m, o, bz, ch, d, e});
  endtask

  // Idle word helper: everything low
  task automatic add_idle(input int n);
    add_seg(3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, n);
  endtask

  // Expected trace for mask=111, dwell={5,3,2}, mix=4, flush=6
  task automatic build_basic();
    exp_q.delete();
    add_seg(3'b001, 0, 0, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b010, 0, 0, 1, 4'd1, 0, 0, 3);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b100, 0, 0, 1, 4'd2, 0, 0, 5);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b000, 1, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b000, 0, 1, 1, 4'd0, 0, 0, 6);
    add_seg(3'b000, 0, 0, 0, 4'd0, 1, 0, 1);
    add_idle(2);
  endtask

  task automatic set_cfg(input logic [2:0] m, input logic [15:0] d2, input logic [15:0] d1,
                         input logic [15:0] d0, input logic [15:0] mx, input logic [15:0] fl);
    b.chan_mask = m;
    b.dwell     = {d2, d1, d0};
    b.mix_cyc   = mx;
    b.flush_cyc = fl;
  endtask

  task automatic test_reset();
    b.start = 0; b.abort = 0; set_cfg(3'b000, 0, 0, 0, 0, 0);
    b4.start = 0; b4.abort = 0; b4.chan_mask = '0; b4.dwell = '0; b4.mix_cyc = '0; b4.flush_cyc = '0;
    #3;
    n_chk++;
    if (obs !== 12'h000) $display("FAIL reset_main: got %b want %b", obs, 12'h000); else n_pass++;
    n_chk++;
    if (obs4 !== 12'h000) $display("FAIL reset_cnt4: got %b want %b", obs4, 12'h000); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== 12'h000) $display("FAIL reset_release: got %b want %b", obs, 12'h000); else n_pass++;
  endtask

  task automatic test_basic();
    int done_at;
    build_basic();
    set_cfg(3'b111, 16'd5, 16'd3, 16'd2, 16'd4, 16'd6);
    @(negedge clk); b.start = 1;
    done_at = 0;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL basic cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
      if (b.done === 1'b1 && done_at == 0) done_at = k;
    end
    n_chk++;
    if (done_at !== 33) $display("FAIL basic_latency: got %0d want %0d", done_at, 33); else n_pass++;
  endtask

  task automatic test_skip();
    exp_q.delete();
    add_seg(3'b001, 0, 0, 1, 4'd0, 0, 0, 3);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b000, 1, 0, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 1, 1, 4'd0, 0, 0, 1);
    add_seg(3'b000, 0, 0, 0, 4'd0, 1, 0, 1);
    add_idle(2);
    set_cfg(3'b101, 16'd0, 16'd0, 16'd3, 16'd2, 16'd1);
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL skip cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_reject();
    exp_q.delete();
    add_seg(3'b000, 0, 0, 0, 4'd0, 0, 1, 1);
    add_idle(3);
    set_cfg(3'b010, 16'd5, 16'd0, 16'd5, 16'd2, 16'd2);
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL reject cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int done_at;
    exp_q.delete();
    add_seg(3'b001, 0, 0, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b010, 0, 0, 1, 4'd1, 0, 0, 2);
    add_seg(3'b000, 0, 0, 0, 4'd0, 0, 1, 1);
    add_idle(3);
    set_cfg(3'b111, 16'd1, 16'd3, 16'd2, 16'd2, 16'd2);
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL abort cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
      b.abort = (k == 8);
    end
    exp_q.delete();
    add_seg(3'b001, 0, 0, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b010, 0, 0, 1, 4'd1, 0, 0, 3);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b100, 0, 0, 1, 4'd2, 0, 0, 1);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b000, 1, 0, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 1, 1, 4'd0, 0, 0, 2);
    add_seg(3'b000, 0, 0, 0, 4'd0, 1, 0, 1);
    add_idle(2);
    @(negedge clk); b.start = 1;
    done_at = 0;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL rerun cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
      if (b.done === 1'b1 && done_at == 0) done_at = k;
    end
    n_chk++;
    if (done_at !== 23) $display("FAIL rerun_latency: got %0d want %0d", done_at, 23); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_cfg(3'b111, 16'd5, 16'd3, 16'd2, 16'd4, 16'd6);
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk); b.start = 0;
    end
    n_chk++;
    if (b.mix_en !== 1'b1) $display("FAIL mid_mix_active: got %b want %b", b.mix_en, 1'b1); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 12'h000) $display("FAIL async_reset: got %b want %b", obs, 12'h000); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (obs !== 12'h000) $display("FAIL post_reset_idle: got %b want %b", obs, 12'h000); else n_pass++;
    build_basic();
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL restart cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    build_basic();
    set_cfg(3'b111, 16'd5, 16'd3, 16'd2, 16'd4, 16'd6);
    @(negedge clk); b.start = 1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b.start = 0;
      n_chk++;
      if (obs !== exp_q[k-1]) $display("FAIL b2b cycle %0d: got %b want %b", k, obs, exp_q[k-1]);
      else n_pass++;
      if (k == 5) set_cfg(3'b001, 16'd9, 16'd9, 16'd9, 16'd1, 16'd1);
      if (k == 10 || k == 33) b.start = 1;
    end
    set_cfg(3'b000, 0, 0, 0, 0, 0);
  endtask

  task automatic test_long();
    int done_at;
    exp_q.delete();
    add_seg(3'b001, 0, 0, 1, 4'd0, 0, 0, 15);
    add_seg(3'b000, 0, 0, 1, 4'd0, 0, 0, 4);
    add_seg(3'b000, 0, 0, 0, 4'd0, 1, 0, 1);
    add_idle(2);
    b4.chan_mask = 3'b001;
    b4.dwell     = {4'd0, 4'd0, 4'd15};
    b4.mix_cyc   = 4'd0;
    b4.flush_cyc = 4'd0;
    @(negedge clk); b4.start = 1;
    done_at = 0;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(negedge clk); b4.start = 0;
      n_chk++;
      if (obs4 !== exp_q[k-1]) $display("FAIL long cycle %0d: got %b want %b", k, obs4, exp_q[k-1]);
      else n_pass++;
      if (b4.done === 1'b1 && done_at == 0) done_at = k;
    end
    n_chk++;
    if (done_at !== 20) $display("FAIL long_latency: got %0d want %0d", done_at, 20); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_reject();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_long();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
